// File: rtl/stream_buffer.sv
// Elastic stream buffer with FIFO or LIFO pop order and valid/ready handshakes on both sides.
// Occupancy, full/empty and almost-full/almost-empty flags are all decoded from the registered count.
module stream_buffer #(
  parameter int DATA_WIDTH          = 8,
  parameter int DEPTH               = 8,
  parameter     POP_ORDER           = "FIFO",
  parameter int ALMOST_FULL_THRESH  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         is_full,
  output logic                         is_empty,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int CW      = $clog2(DEPTH + 1);
  localparam int PW      = $clog2(DEPTH);
  localparam bit IS_LIFO = (POP_ORDER == "LIFO");

  if (POP_ORDER != "FIFO" && POP_ORDER != "LIFO") begin : g_bad_order
    $error("stream_buffer: POP_ORDER must be \"FIFO\" or \"LIFO\"");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         top;
  logic [PW-1:0]         wr_addr;
  logic [PW-1:0]         rd_addr;
  logic                  push;
  logic                  pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign count        = cnt;
  assign is_full      = (cnt == CW'(DEPTH));
  assign is_empty     = (cnt == '0);
  assign almost_full  = (cnt >= CW'(ALMOST_FULL_THRESH));
  assign almost_empty = (cnt <= CW'(ALMOST_EMPTY_THRESH));
  assign in_ready     = !is_full;
  assign out_valid    = !is_empty;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // In LIFO mode a simultaneous push overwrites the slot being popped.
  assign top     = PW'(cnt - 1'b1);
  assign rd_addr = IS_LIFO ? top : rd_ptr;
  assign wr_addr = IS_LIFO ? (pop ? top : PW'(cnt)) : wr_ptr;

  assign out_data = is_empty ? '0 : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_buffer.sv
// Directed bench for stream_buffer: FIFO depth 4, FIFO depth 3 and LIFO depth 4 instances.
// Each task drives one scenario and compares against hand-computed values.
module tb_stream_buffer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // FIFO, DEPTH=4
  logic       f4_flush, f4_in_valid, f4_in_ready, f4_out_valid, f4_out_ready;
  logic [7:0] f4_in_data, f4_out_data;
  logic [2:0] f4_count;
  logic       f4_is_full, f4_is_empty, f4_almost_full, f4_almost_empty;
  // FIFO, DEPTH=3
  logic       f3_flush, f3_in_valid, f3_in_ready, f3_out_valid, f3_out_ready;
  logic [7:0] f3_in_data, f3_out_data;
  logic [1:0] f3_count;
  logic       f3_is_full, f3_is_empty, f3_almost_full, f3_almost_empty;
  // LIFO, DEPTH=4
  logic       l4_flush, l4_in_valid, l4_in_ready, l4_out_valid, l4_out_ready;
  logic [7:0] l4_in_data, l4_out_data;
  logic [2:0] l4_count;
  logic       l4_is_full, l4_is_empty, l4_almost_full, l4_almost_empty;

  stream_buffer #(.DATA_WIDTH(8), .DEPTH(4), .POP_ORDER("FIFO")) u_fifo4 (
    .clk(clk), .rst_n(rst_n), .flush(f4_flush),
    .in_valid(f4_in_valid), .in_ready(f4_in_ready), .in_data(f4_in_data),
    .out_valid(f4_out_valid), .out_ready(f4_out_ready), .out_data(f4_out_data),
    .count(f4_count), .is_full(f4_is_full), .is_empty(f4_is_empty),
    .almost_full(f4_almost_full), .almost_empty(f4_almost_empty));

  stream_buffer #(.DATA_WIDTH(8), .DEPTH(3), .POP_ORDER("FIFO")) u_fifo3 (
    .clk(clk), .rst_n(rst_n), .flush(f3_flush),
    .in_valid(f3_in_valid), .in_ready(f3_in_ready), .in_data(f3_in_data),
    .out_valid(f3_out_valid), .out_ready(f3_out_ready), .out_data(f3_out_data),
    .count(f3_count), .is_full(f3_is_full), .is_empty(f3_is_empty),
    .almost_full(f3_almost_full), .almost_empty(f3_almost_empty));

  stream_buffer #(.DATA_WIDTH(8), .DEPTH(4), .POP_ORDER("LIFO")) u_lifo4 (
    .clk(clk), .rst_n(rst_n), .flush(l4_flush),
    .in_valid(l4_in_valid), .in_ready(l4_in_ready), .in_data(l4_in_data),
    .out_valid(l4_out_valid), .out_ready(l4_out_ready), .out_data(l4_out_data),
    .count(l4_count), .is_full(l4_is_full), .is_empty(l4_is_empty),
    .almost_full(l4_almost_full), .almost_empty(l4_almost_empty));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f4_flush = 0; f4_in_valid = 0; f4_in_data = 0; f4_out_ready = 0;
    f3_flush = 0; f3_in_valid = 0; f3_in_data = 0; f3_out_ready = 0;
    l4_flush = 0; l4_in_valid = 0; l4_in_data = 0; l4_out_ready = 0;
    #12;
    checks++; if (f4_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", f4_count); end
    checks++; if (f4_is_empty !== 1'b1 || f4_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b%b want 11", f4_is_empty, f4_almost_empty); end
    checks++; if (f4_is_full !== 1'b0 || f4_almost_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b want 00", f4_is_full, f4_almost_full); end
    checks++; if (f4_out_valid !== 1'b0 || f4_out_data !== 8'h00 || f4_in_ready !== 1'b1) begin errors++; $display("FAIL reset_hs got ov=%b od=%h ir=%b want 0 00 1", f4_out_valid, f4_out_data, f4_in_ready); end
    checks++; if (f3_count !== 2'd0 || l4_count !== 3'd0 || l4_out_data !== 8'h00) begin errors++; $display("FAIL reset_others got f3=%0d l4=%0d l4od=%h want 0 0 00", f3_count, l4_count, l4_out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fifo_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      f4_in_valid = 1'b1; f4_in_data = vals[i];
      #1;
      checks++; if (f4_in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %b want 1", i, f4_in_ready); end
      tick();
      checks++; if (f4_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, f4_count, i + 1); end
      checks++; if (f4_almost_full !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_almost_full[%0d] got %b want %b", i, f4_almost_full, (i + 1 >= 3)); end
      checks++; if (f4_almost_empty !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_almost_empty[%0d] got %b want %b", i, f4_almost_empty, (i + 1 <= 1)); end
      checks++; if (f4_out_data !== 8'h11) begin errors++; $display("FAIL fill_head[%0d] got %h want 11", i, f4_out_data); end
    end
    f4_in_valid = 1'b0;
    #1;
    checks++; if (f4_is_full !== 1'b1 || f4_in_ready !== 1'b0) begin errors++; $display("FAIL full_flags got full=%b ir=%b want 1 0", f4_is_full, f4_in_ready); end
    f4_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (f4_out_valid !== 1'b1 || f4_out_data !== vals[i]) begin errors++; $display("FAIL drain_data[%0d] got v=%b %h want 1 %h", i, f4_out_valid, f4_out_data, vals[i]); end
      tick();
    end
    f4_out_ready = 1'b0;
    checks++; if (f4_is_empty !== 1'b1 || f4_count !== 3'd0 || f4_out_data !== 8'h00) begin errors++; $display("FAIL drain_empty got e=%b c=%0d od=%h want 1 0 00", f4_is_empty, f4_count, f4_out_data); end
  endtask

  task automatic test_fifo_wrap();
    f3_in_valid = 1'b1; f3_in_data = 8'h50; f3_out_ready = 1'b0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      f3_in_valid = 1'b1; f3_in_data = 8'(8'h50 + i); f3_out_ready = 1'b1;
      #1;
      checks++; if (f3_out_data !== 8'(8'h50 + i - 1) || f3_count !== 2'd1) begin errors++; $display("FAIL wrap_stream[%0d] got %h c=%0d want %h c=1", i, f3_out_data, f3_count, 8'(8'h50 + i - 1)); end
      tick();
    end
    f3_in_valid = 1'b0;
    #1;
    checks++; if (f3_out_data !== 8'h5A || f3_count !== 2'd1) begin errors++; $display("FAIL wrap_last got %h c=%0d want 5a c=1", f3_out_data, f3_count); end
    tick();
    f3_out_ready = 1'b0;
    checks++; if (f3_is_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", f3_is_empty); end
  endtask

  task automatic test_full_simultaneous();
    for (int i = 0; i < 4; i++) begin
      f4_in_valid = 1'b1; f4_in_data = 8'(8'h61 + i);
      tick();
    end
    f4_in_data = 8'h65; f4_out_ready = 1'b1;
    #1;
    checks++; if (f4_in_ready !== 1'b0 || f4_out_data !== 8'h61) begin errors++; $display("FAIL fullsim_pre got ir=%b od=%h want 0 61", f4_in_ready, f4_out_data); end
    tick();
    checks++; if (f4_count !== 3'd3 || f4_in_ready !== 1'b1 || f4_out_data !== 8'h62) begin errors++; $display("FAIL fullsim_post got c=%0d ir=%b od=%h want 3 1 62", f4_count, f4_in_ready, f4_out_data); end
    f4_out_ready = 1'b0;
    tick();
    f4_in_valid = 1'b0;
    checks++; if (f4_count !== 3'd4) begin errors++; $display("FAIL fullsim_accept got %0d want 4", f4_count); end
    f4_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (f4_out_data !== 8'(8'h62 + i)) begin errors++; $display("FAIL fullsim_drain[%0d] got %h want %h", i, f4_out_data, 8'(8'h62 + i)); end
      tick();
    end
    f4_out_ready = 1'b0;
  endtask

  task automatic test_lifo();
    l4_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      l4_in_valid = 1'b1; l4_in_data = 8'(8'h0A + i);
      tick();
    end
    checks++; if (l4_count !== 3'd3 || l4_out_data !== 8'h0C) begin errors++; $display("FAIL lifo_top got c=%0d od=%h want 3 0c", l4_count, l4_out_data); end
    l4_in_data = 8'h0D; l4_out_ready = 1'b1;
    #1;
    checks++; if (l4_out_data !== 8'h0C) begin errors++; $display("FAIL lifo_simpop got %h want 0c", l4_out_data); end
    tick();
    l4_in_valid = 1'b0;
    #1;
    checks++; if (l4_count !== 3'd3 || l4_out_data !== 8'h0D) begin errors++; $display("FAIL lifo_simpush got c=%0d od=%h want 3 0d", l4_count, l4_out_data); end
    tick();
    checks++; if (l4_out_data !== 8'h0B) begin errors++; $display("FAIL lifo_pop2 got %h want 0b", l4_out_data); end
    tick();
    checks++; if (l4_out_data !== 8'h0A) begin errors++; $display("FAIL lifo_pop3 got %h want 0a", l4_out_data); end
    tick();
    l4_out_ready = 1'b0;
    checks++; if (l4_is_empty !== 1'b1 || l4_out_data !== 8'h00) begin errors++; $display("FAIL lifo_empty got e=%b od=%h want 1 00", l4_is_empty, l4_out_data); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      f4_in_valid = 1'b1; f4_in_data = 8'(8'h71 + i);
      tick();
    end
    f4_flush = 1'b1; f4_in_data = 8'h74; f4_out_ready = 1'b1;
    #1;
    checks++; if (f4_in_ready !== 1'b1 || f4_count !== 3'd3) begin errors++; $display("FAIL flush_pre got ir=%b c=%0d want 1 3", f4_in_ready, f4_count); end
    tick();
    f4_flush = 1'b0; f4_in_valid = 1'b0; f4_out_ready = 1'b0;
    #1;
    checks++; if (f4_count !== 3'd0 || f4_is_empty !== 1'b1 || f4_out_valid !== 1'b0 || f4_out_data !== 8'h00) begin errors++; $display("FAIL flush_post got c=%0d e=%b ov=%b od=%h want 0 1 0 00", f4_count, f4_is_empty, f4_out_valid, f4_out_data); end
    f4_in_valid = 1'b1; f4_in_data = 8'h75;
    tick();
    f4_in_valid = 1'b0;
    checks++; if (f4_count !== 3'd1 || f4_out_data !== 8'h75) begin errors++; $display("FAIL flush_reuse got c=%0d od=%h want 1 75", f4_count, f4_out_data); end
    f4_out_ready = 1'b1;
    tick();
    f4_out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    f4_in_valid = 1'b1; f4_in_data = 8'h81;
    tick();
    f4_in_data = 8'h82;
    tick();
    f4_in_valid = 1'b0;
    checks++; if (f4_count !== 3'd2) begin errors++; $display("FAIL arst_pre got %0d want 2", f4_count); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (f4_count !== 3'd0 || f4_out_valid !== 1'b0 || f4_out_data !== 8'h00 || f4_in_ready !== 1'b1 || f4_is_empty !== 1'b1) begin errors++; $display("FAIL arst_now got c=%0d ov=%b od=%h ir=%b e=%b want 0 0 00 1 1", f4_count, f4_out_valid, f4_out_data, f4_in_ready, f4_is_empty); end
    #1 rst_n = 1'b1;
    tick();
    f4_in_valid = 1'b1; f4_in_data = 8'h90;
    #1;
    checks++; if (f4_out_valid !== 1'b0) begin errors++; $display("FAIL arst_nobypass got %b want 0", f4_out_valid); end
    tick();
    f4_in_valid = 1'b0;
    checks++; if (f4_out_valid !== 1'b1 || f4_out_data !== 8'h90) begin errors++; $display("FAIL arst_first got ov=%b od=%h want 1 90", f4_out_valid, f4_out_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fifo_fill_drain();
    test_fifo_wrap();
    test_full_simultaneous();
    test_lifo();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
